regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the next-generation RISC-V core, replacing the single-write/dual-read file in the decode stage. It provides NRD combinational read ports with write-through forwarding and NWR write ports with fixed priority. A post-reset clear sequencer zeroes the array so it can map to FPGA block/MLAB RAM without a reset path. A per-register pending scoreboard lets the issue logic detect RAW hazards on in-flight writebacks.

---
 rtl/regfile_mp_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 53 +++++
 rtl/regfile_mp.sv | 116 +++++++++++
 tb/tb_regfile_mp.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared register-file definitions: data/address bus widths and the
// clear-sequencer state encoding used by decode, hazard and writeback logic.
package regfile_mp_pkg;

  localparam int unsigned RF_XLEN   = 32;
  localparam int unsigned RF_NREG   = 32;
  localparam int unsigned RF_ADDR_W = $clog2(RF_NREG);
  localparam int unsigned RF_DATA_W = RF_XLEN;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for in-flight writebacks, with set-over-clear
// priority and a combinational lookup for each read port.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int unsigned NREG     = RF_NREG,
  parameter int unsigned AW       = $clog2(NREG),
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic              sb_set_i,
  input  logic [AW-1:0]     sb_addr_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    rd_pend_o
);

  logic [NREG-1:0] pend_q, pend_d;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Set is applied after the clears so a newly issued owner keeps the bit.
  always_comb begin
    pend_d = pend_q;
    if (en_i) begin
      for (int unsigned p = 0; p < NWR; p++) begin
        if (wr_en_i[p] && !is_zero(wr_addr_i[p*AW +: AW]))
          pend_d[wr_addr_i[p*AW +: AW]] = 1'b0;
      end
      if (sb_set_i && !is_zero(sb_addr_i))
        pend_d[sb_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) pend_q <= '0;
    else      pend_q <= pend_d;
  end

  always_comb begin
    rd_pend_o = '0;
    for (int unsigned r = 0; r < NRD; r++)
      rd_pend_o[r] = pend_q[rd_addr_i[r*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: fixed-priority writes, write-through
// forwarding on reads, and a post-reset clear sequencer for reset-less RAM.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned XLEN     = RF_XLEN,
  parameter int unsigned NREG     = RF_NREG,
  parameter int unsigned AW       = $clog2(NREG),
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pending,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  output logic                init_busy
);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   clr_q, clr_d;
  logic [XLEN-1:0] mem_q [NREG];
  logic [NRD-1:0]  sb_pend;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (state_q == CLEAR) begin
      clr_d = clr_q + 1'b1;
      if (clr_q == AW'(NREG - 1)) state_d = READY;
    end
  end

  always_comb begin
    init_busy = (state_q == CLEAR);
  end

  // No reset on the array itself; ascending port order lets the higher port win.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == CLEAR) begin
        mem_q[clr_q] <= '0;
      end else begin
        for (int unsigned p = 0; p < NWR; p++) begin
          if (wr_en[p] && !is_zero(wr_addr[p*AW +: AW]))
            mem_q[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREG     (NREG),
    .AW       (AW),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q == READY),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .sb_set_i  (sb_set),
    .sb_addr_i (sb_addr),
    .rd_addr_i (rd_addr),
    .rd_pend_o (sb_pend)
  );

  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] d;
    logic            pnd;
    rd_data    = '0;
    rd_pending = '0;
    for (int unsigned r = 0; r < NRD; r++) begin
      ra  = rd_addr[r*AW +: AW];
      d   = mem_q[ra];
      pnd = sb_pend[r];
      for (int unsigned p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] == ra)) begin
          d   = wr_data[p*XLEN +: XLEN];
          pnd = 1'b0;
        end
      end
      if (!rst || (state_q == CLEAR) || !rd_en[r] || is_zero(ra)) begin
        d   = '0;
        pnd = 1'b0;
      end
      rd_data[r*XLEN +: XLEN] = d;
      rd_pending[r]           = pnd;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp with default parameters
// (32x32, two read ports, two write ports, register 0 hardwired).
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pending;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        init_busy;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN     (32),
    .NREG     (32),
    .NRD      (2),
    .NWR      (2),
    .ZERO_REG (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .sb_set     (sb_set),
    .sb_addr    (sb_addr),
    .init_busy  (init_busy)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        sb;
    logic [4:0]  sba;
    logic [31:0] d0;
    logic        p0;
    logic [31:0] d1;
    logic        p1;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  vec_t vt[13];

  task automatic push_exp(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] act);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_mis++;
      $display("FAIL scoreboard_underflow got=%h required=<queued value>", act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e.val) begin
        n_mis++;
        $display("FAIL %s got=%h required=%h", e.name, act, e.val);
      end
    end
  endtask

  task automatic push_reads(input string n, input logic [31:0] d0, input logic p0,
                            input logic [31:0] d1, input logic p1);
    push_exp({n, "_d0"}, d0);
    push_exp({n, "_p0"}, {31'b0, p0});
    push_exp({n, "_d1"}, d1);
    push_exp({n, "_p1"}, {31'b0, p1});
  endtask

  task automatic sample_reads();
    pop_cmp(rd_data[31:0]);
    pop_cmp({31'b0, rd_pending[0]});
    pop_cmp(rd_data[63:32]);
    pop_cmp({31'b0, rd_pending[1]});
  endtask

  task automatic set_write(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                           input logic [4:0] a1, input logic [31:0] d1);
    wr_en   = we;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
  endtask

  task automatic set_read(input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1);
    rd_en   = re;
    rd_addr = {a1, a0};
  endtask

  task automatic idle();
    set_write(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    sb_set  = 1'b0;
    sb_addr = 5'd0;
  endtask

  // Entered just after a falling edge; returns #1 after the first falling
  // edge with init_busy low. junk=1 drives writes/sb_set that must be dropped.
  task automatic wait_clear(input bit junk, output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!init_busy) break;
      cnt++;
      if (junk) begin
        set_write(2'b11, 5'd1, 32'hBAD0BAD0, 5'd1, 32'hBAD1BAD1);
        sb_set  = 1'b1;
        sb_addr = 5'd2;
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic check_len(input string n, input int cnt);
    push_exp(n, 32'd32);
    pop_cmp(cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;

    vt[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b11, 5'd5, 5'd6, 1'b0, 5'd0,
               32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
    vt[1]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd7, 1'b0, 5'd0,
               32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
    vt[2]  = '{2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 2'b11, 5'd7, 5'd5, 1'b0, 5'd0,
               32'h22222222, 1'b0, 32'hDEADBEEF, 1'b0};
    vt[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd7, 1'b0, 5'd0,
               32'h22222222, 1'b0, 32'h0, 1'b0};
    vt[4]  = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 1'b1, 5'd0,
               32'h0, 1'b0, 32'h0, 1'b0};
    vt[5]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd9, 1'b1, 5'd9,
               32'h0, 1'b0, 32'h0, 1'b0};
    vt[6]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd0, 1'b0, 5'd0,
               32'h0, 1'b1, 32'h0, 1'b0};
    vt[7]  = '{2'b10, 5'd0, 32'h0, 5'd9, 32'h00000099, 2'b11, 5'd9, 5'd9, 1'b1, 5'd9,
               32'h00000099, 1'b0, 32'h00000099, 1'b0};
    vt[8]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd9, 1'b0, 5'd0,
               32'h00000099, 1'b1, 32'h00000099, 1'b1};
    vt[9]  = '{2'b01, 5'd9, 32'h00000123, 5'd0, 32'h0, 2'b11, 5'd9, 5'd9, 1'b0, 5'd0,
               32'h00000123, 1'b0, 32'h00000123, 1'b0};
    vt[10] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd7, 1'b0, 5'd0,
               32'h00000123, 1'b0, 32'h22222222, 1'b0};
    vt[11] = '{2'b10, 5'd0, 32'h0, 5'd4, 32'h00000044, 2'b10, 5'd4, 5'd4, 1'b0, 5'd0,
               32'h0, 1'b0, 32'h00000044, 1'b0};
    vt[12] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd4, 5'd3, 1'b0, 5'd0,
               32'h00000044, 1'b0, 32'h0, 1'b0};

    // Reset: outputs gated even with a matching write present.
    rst = 1'b0;
    idle();
    set_write(2'b01, 5'd5, 32'h12345678, 5'd0, 32'h0);
    set_read(2'b11, 5'd5, 5'd5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    push_reads("reset", 32'h0, 1'b0, 32'h0, 1'b0);
    sample_reads();
    push_exp("reset_init_busy", 32'd1);
    pop_cmp({31'b0, init_busy});
    idle();
    @(negedge clk);
    rst = 1'b1;
    wait_clear(1'b1, cnt);
    check_len("clear_len", cnt);

    // Every register reads zero, no pending bits (reg 1 / reg 2 junk dropped).
    for (int i = 0; i < 16; i++) begin
      set_read(2'b11, 5'(2 * i), 5'(2 * i + 1));
      push_reads($sformatf("clr_r%0d", 2 * i), 32'h0, 1'b0, 32'h0, 1'b0);
      #1;
      sample_reads();
      @(negedge clk);
    end

    for (int i = 0; i < 13; i++) begin
      set_write(vt[i].we, vt[i].wa0, vt[i].wd0, vt[i].wa1, vt[i].wd1);
      set_read(vt[i].re, vt[i].ra0, vt[i].ra1);
      sb_set  = vt[i].sb;
      sb_addr = vt[i].sba;
      push_reads($sformatf("vec%0d", i), vt[i].d0, vt[i].p0, vt[i].d1, vt[i].p1);
      #1;
      sample_reads();
      @(negedge clk);
    end
    idle();

    // Mid-CLEAR reset restarts the full clear.
    set_write(2'b01, 5'd3, 32'hA5A5A5A5, 5'd0, 32'h0);
    set_read(2'b11, 5'd3, 5'd3);
    push_reads("wr3_fwd", 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0);
    #1;
    sample_reads();
    @(negedge clk);
    idle();
    push_reads("wr3_arr", 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0);
    #1;
    sample_reads();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    push_reads("midclr_rst", 32'h0, 1'b0, 32'h0, 1'b0);
    sample_reads();
    @(negedge clk);
    rst = 1'b1;
    wait_clear(1'b0, cnt);
    check_len("midclr_len", cnt);
    set_read(2'b11, 5'd3, 5'd3);
    push_reads("midclr_r3", 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    sample_reads();
    @(negedge clk);

    // Reset while READY: write dropped in the reset cycle, clear wipes reg 3.
    set_write(2'b10, 5'd0, 32'h0, 5'd3, 32'hA5A5A5A5);
    @(negedge clk);
    rst = 1'b0;
    set_write(2'b01, 5'd3, 32'h5A5A5A5A, 5'd0, 32'h0);
    sb_set  = 1'b1;
    sb_addr = 5'd3;
    @(negedge clk);
    idle();
    rst = 1'b1;
    wait_clear(1'b0, cnt);
    check_len("rdyrst_len", cnt);
    set_read(2'b11, 5'd3, 5'd3);
    push_reads("rdyrst_r3", 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    sample_reads();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
